// File: rtl/gcd_pkg.sv
// Shared constants and driver FSM encoding for the GCD core, its request driver and benches.
// Pure declarations: no latency, no backpressure.
package gcd_pkg;

    localparam int GCD_WIDTH   = 8;
    localparam int GCD_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } drv_state_t;

endpackage

// File: rtl/gcd_drv_timer.sv
// Transaction timer: clr restarts counting, en advances it, tc marks count TIMEOUT-1.
// One-cycle register latency, no backpressure; GCD_DRV_LAT_EN exports the count as a latency value.
module gcd_drv_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic             tc
`ifdef GCD_DRV_LAT_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    logic [CNT_W-1:0] cnt_q;

    // The clear cycle is elapsed cycle 0, so the first counted cycle after it reads 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= CNT_W'(1);
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc = (cnt_q == CNT_W'(TIMEOUT - 1));

`ifdef GCD_DRV_LAT_EN
    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/gcd_req_driver.sv
// Initiator for the GCD START/DONE handshake; one outstanding request, result held until OUT_READY.
// OUT_VALID rises one cycle after DONE (or timeout); GCD_DRV_LAT_EN adds OUT_LAT/MAX_LAT latency outputs.
module gcd_req_driver
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = GCD_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_A,
    input  logic [WIDTH-1:0] IN_B,
    output logic             GCD_START,
    output logic [WIDTH-1:0] GCD_A,
    output logic [WIDTH-1:0] GCD_B,
    input  logic [WIDTH-1:0] GCD_Y,
    input  logic             GCD_DONE,
    input  logic             GCD_ERROR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_Y,
    output logic             OUT_ERR,
    output logic             OUT_TO
`ifdef GCD_DRV_LAT_EN
    ,
    output logic [CNT_W-1:0] OUT_LAT,
    output logic [CNT_W-1:0] MAX_LAT
`endif
);

    drv_state_t state_q, state_d;
    logic       tc;

`ifdef GCD_DRV_LAT_EN
    logic [CNT_W-1:0] cnt;
`endif

    gcd_drv_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk (CLK),
        .rst (RST),
        .clr (state_q == ISSUE),
        .en  (state_q == WAIT),
        .tc  (tc)
`ifdef GCD_DRV_LAT_EN
        ,
        .cnt (cnt)
`endif
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake strobes are state decodes, masked while reset drops the transaction.
    always_comb begin
        state_d   = state_q;
        IN_READY  = 1'b0;
        GCD_START = 1'b0;
        OUT_VALID = 1'b0;
        case (state_q)
            IDLE: begin
                IN_READY = !RST;
                if (IN_VALID) state_d = ISSUE;
            end
            ISSUE: begin
                GCD_START = !RST;
                state_d   = WAIT;
            end
            WAIT: begin
                if (GCD_DONE || tc) state_d = HOLD;
            end
            HOLD: begin
                OUT_VALID = !RST;
                if (OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            GCD_A   <= '0;
            GCD_B   <= '0;
            OUT_Y   <= '0;
            OUT_ERR <= 1'b0;
            OUT_TO  <= 1'b0;
        end else begin
            if (state_q == IDLE && IN_VALID) begin
                GCD_A <= IN_A;
                GCD_B <= IN_B;
            end
            // DONE has priority over a coinciding timeout.
            if (state_q == WAIT) begin
                if (GCD_DONE) begin
                    OUT_Y   <= GCD_Y;
                    OUT_ERR <= GCD_ERROR;
                    OUT_TO  <= 1'b0;
                end else if (tc) begin
                    OUT_Y   <= '0;
                    OUT_ERR <= 1'b0;
                    OUT_TO  <= 1'b1;
                end
            end
        end
    end

`ifdef GCD_DRV_LAT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_LAT <= '0;
            MAX_LAT <= '0;
        end else if (state_q == WAIT) begin
            if (GCD_DONE) begin
                OUT_LAT <= cnt;
                if (cnt > MAX_LAT) MAX_LAT <= cnt;
            end else if (tc) begin
                OUT_LAT <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gcd_req_driver.sv
// Directed bench for gcd_req_driver with a behavioural GCD core responder (TIMEOUT=16).
// Latency outputs are checked when GCD_DRV_LAT_EN is defined.
module tb_gcd_req_driver;

    localparam int W  = 8;
    localparam int TO = 16;
    localparam int CW = 16;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         gcd_start;
    logic [W-1:0] gcd_a, gcd_b;
    logic [W-1:0] gcd_y     = '0;
    logic         gcd_done  = 1'b0;
    logic         gcd_error = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_y;
    logic         out_err, out_to;
`ifdef GCD_DRV_LAT_EN
    logic [CW-1:0] out_lat, max_lat;
`endif

    int cyc        = 0;
    int start_cnt  = 0;
    int last_start = -1;
    int n_cmp      = 0;
    int n_bad      = 0;

    int           core_dly = 5;
    int           core_len = 1;
    logic [W-1:0] core_y   = '0;
    logic         core_err = 1'b0;

    gcd_req_driver #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK       (clk),
        .RST       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_A      (in_a),
        .IN_B      (in_b),
        .GCD_START (gcd_start),
        .GCD_A     (gcd_a),
        .GCD_B     (gcd_b),
        .GCD_Y     (gcd_y),
        .GCD_DONE  (gcd_done),
        .GCD_ERROR (gcd_error),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_Y     (out_y),
        .OUT_ERR   (out_err),
        .OUT_TO    (out_to)
`ifdef GCD_DRV_LAT_EN
        ,
        .OUT_LAT   (out_lat),
        .MAX_LAT   (max_lat)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gcd_start) begin
            start_cnt  <= start_cnt + 1;
            last_start <= cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Core responder: DONE goes high core_dly cycles after the START cycle, for core_len cycles.
    task automatic serve();
        int           dly = core_dly;
        int           len = core_len;
        logic [W-1:0] y   = core_y;
        logic         e   = core_err;
        repeat (dly) @(posedge clk);
        #1;
        gcd_done  = 1'b1;
        gcd_y     = y;
        gcd_error = e;
        repeat (len) @(posedge clk);
        #1;
        gcd_done  = 1'b0;
        gcd_y     = '0;
        gcd_error = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (gcd_start) serve();
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int hs);
        int n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("send_accept", in_ready, 1);
        hs = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        int n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check_eq("out_valid_seen", out_valid, 1);
        c = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   hs, ov, ov1, n_ov, n_st;
        logic ok;

        // Reset
        tick();
        check_eq("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1);
        check_eq("post_rst_start", gcd_start, 0);
        check_eq("post_rst_out_valid", out_valid, 0);
        check_eq("post_rst_out_y", out_y, 0);
        check_eq("post_rst_out_err", out_err, 0);
        check_eq("post_rst_out_to", out_to, 0);
        check_eq("post_rst_gcd_a", gcd_a, 0);
        tick();

        // (21,6): DONE 5 cycles after START, DONE level held 3 cycles
        core_dly = 5; core_len = 3; core_y = 8'd3; core_err = 1'b0;
        send(8'd21, 8'd6, hs);
        wait_out(ov);
        check_eq("t1_out_latency", ov - hs, 7);
        check_eq("t1_start_cycle", last_start, hs + 1);
        check_eq("t1_out_y", out_y, 3);
        check_eq("t1_out_err", out_err, 0);
        check_eq("t1_out_to", out_to, 0);
        check_eq("t1_gcd_a", gcd_a, 21);
`ifdef GCD_DRV_LAT_EN
        check_eq("t1_out_lat", out_lat, 5);
`endif
        tick();
        check_eq("t1_valid_drop", out_valid, 0);

        // (75,60) then (0,0) back-to-back
        core_dly = 2; core_len = 1; core_y = 8'd15; core_err = 1'b0;
        send(8'd75, 8'd60, hs);
        wait_out(ov1);
        check_eq("t2a_out_y", out_y, 15);
        check_eq("t2a_out_err", out_err, 0);
`ifdef GCD_DRV_LAT_EN
        check_eq("t2a_out_lat", out_lat, 2);
`endif
        core_dly = 9; core_y = 8'd0; core_err = 1'b1;
        send(8'd0, 8'd0, hs);
        check_eq("t2_b2b_handshake", hs, ov1 + 1);
        wait_out(ov);
        check_eq("t2_b2b_start", last_start, ov1 + 2);
        check_eq("t2b_out_y", out_y, 0);
        check_eq("t2b_out_err", out_err, 1);
        check_eq("t2b_out_to", out_to, 0);
`ifdef GCD_DRV_LAT_EN
        check_eq("t2b_out_lat", out_lat, 9);
`endif
        tick();

        // (0,6): core error flag passes through
        core_dly = 4; core_y = 8'd0; core_err = 1'b1;
        send(8'd0, 8'd6, hs);
        wait_out(ov);
        check_eq("t3_out_err", out_err, 1);
        check_eq("t3_out_to", out_to, 0);
        check_eq("t3_gcd_a_held", gcd_a, 0);
        check_eq("t3_gcd_b_held", gcd_b, 6);
`ifdef GCD_DRV_LAT_EN
        check_eq("t3_out_lat", out_lat, 4);
`endif
        tick();

        // Timeout: DONE arrives at START+20, long after the TIMEOUT=16 expiry
        core_dly = 20; core_y = 8'd99; core_err = 1'b0;
        send(8'd9, 8'd3, hs);
        wait_out(ov);
        check_eq("t4_timeout_cycle", ov - last_start, 16);
        check_eq("t4_out_to", out_to, 1);
        check_eq("t4_out_y", out_y, 0);
        check_eq("t4_out_err", out_err, 0);
`ifdef GCD_DRV_LAT_EN
        check_eq("t4_out_lat", out_lat, 0);
`endif
        tick();
        n_ov = 0;
        n_st = start_cnt;
        repeat (8) begin
            if (out_valid) n_ov++;
            tick();
        end
        check_eq("t4_late_done_ignored", n_ov, 0);
        check_eq("t4_no_extra_start", start_cnt, n_st);
        check_eq("t4_idle_ready", in_ready, 1);

        // Downstream stall in HOLD with the next pair already offered
        out_ready = 1'b0;
        core_dly = 3; core_y = 8'd7; core_err = 1'b0;
        send(8'd14, 8'd21, hs);
        wait_out(ov);
        n_st     = start_cnt;
        in_valid = 1'b1;
        in_a     = 8'd8;
        in_b     = 8'd12;
        ok       = 1'b1;
        repeat (4) begin
            tick();
            if (in_ready || !out_valid || out_y != 8'd7 || gcd_a != 8'd14) ok = 1'b0;
        end
        check_eq("t5_hold_stable", ok, 1);
        check_eq("t5_no_extra_start", start_cnt, n_st);
        core_y    = 8'd4;
        out_ready = 1'b1;
        tick();
        check_eq("t5_ready_after_out", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_eq("t5_next_start", gcd_start, 1);
        check_eq("t5_next_gcd_a", gcd_a, 8);
        wait_out(ov);
        check_eq("t5_next_out_y", out_y, 4);
`ifdef GCD_DRV_LAT_EN
        check_eq("t5_max_lat", max_lat, 9);
`endif
        tick();

        // Reset pulsed during WAIT; DONE lands two cycles later in IDLE
        core_dly = 5; core_y = 8'd2; core_err = 1'b0;
        send(8'd4, 8'd6, hs);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("t6_rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        n_ov = 0;
        n_st = start_cnt;
        repeat (6) begin
            if (out_valid) n_ov++;
            tick();
        end
        check_eq("t6_no_out_valid", n_ov, 0);
        check_eq("t6_no_start", start_cnt, n_st);
        check_eq("t6_out_y", out_y, 0);
        check_eq("t6_out_err", out_err, 0);
        check_eq("t6_out_to", out_to, 0);
        check_eq("t6_gcd_a", gcd_a, 0);
        check_eq("t6_gcd_b", gcd_b, 0);
        check_eq("t6_in_ready", in_ready, 1);
`ifdef GCD_DRV_LAT_EN
        check_eq("t6_out_lat", out_lat, 0);
        check_eq("t6_max_lat", max_lat, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
